// File: rtl/adc_trig_capture.sv
// Triggered single-channel ADC capture with a circular pre-trigger buffer,
// slope/hysteresis trigger, auto-mode timeout and oldest-first readout.
module adc_trig_capture #(
  parameter int DW           = 8,
  parameter int DEPTH        = 1024,
  parameter int AW           = 10,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [DW-1:0] AD_Data,
  input  logic [DW-1:0] Trigger,
  input  logic [DW-1:0] Hyst,
  input  logic          Edge_sel,
  input  logic          Auto_mode,
  input  logic [AW-1:0] Pre_len,
  input  logic          Cap_bg,
  input  logic          rd_en,
  output logic          Cap_end,
  output logic          Triggered,
  output logic          empty,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_ARM  = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(AUTO_TIMEOUT - 1);
  localparam logic [AW-1:0] P_MAX  = AW'(DEPTH - 1);

  logic [DW-1:0] ram [DEPTH];

  logic [2:0]    state;
  logic [AW-1:0] plen;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] cnt;
  logic [AW-1:0] rd_cnt;
  logic [TW-1:0] tcnt;
  logic          armed;

  logic          we;
  logic [DW:0]   sum;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;
  logic          arm_hit;
  logic          lvl_hit;
  logic          real_fire;
  logic          auto_fire;
  logic [AW-1:0] post_last;

  assign we = (state == S_PRE) || (state == S_ARM) || (state == S_POST);

  // Hysteresis band saturates at both ends of the sample range
  assign sum = {1'b0, Trigger} + {1'b0, Hyst};
  assign hi  = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];
  assign lo  = (Hyst > Trigger) ? '0 : Trigger - Hyst;

  assign arm_hit   = Edge_sel ? (AD_Data > hi) : (AD_Data < lo);
  assign lvl_hit   = Edge_sel ? (AD_Data <= Trigger) : (AD_Data >= Trigger);
  assign real_fire = armed && lvl_hit;
  assign auto_fire = Auto_mode && (tcnt == T_LAST);
  assign post_last = P_MAX - plen - 1'b1;

  always_ff @(posedge Clk) begin
    if (we) ram[wr_ptr] <= AD_Data;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      plen      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      rd_cnt    <= '0;
      tcnt      <= '0;
      armed     <= 1'b0;
      Cap_end   <= 1'b0;
      Triggered <= 1'b0;
      empty     <= 1'b1;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (!Cap_bg) begin
        state   <= S_IDLE;
        Cap_end <= 1'b0;
        empty   <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            // Port width already bounds Pre_len to DEPTH-1
            plen      <= Pre_len;
            wr_ptr    <= '0;
            cnt       <= '0;
            rd_cnt    <= '0;
            tcnt      <= '0;
            armed     <= 1'b0;
            Triggered <= 1'b0;
            state     <= (Pre_len == '0) ? S_ARM : S_PRE;
          end
          S_PRE: begin
            wr_ptr <= wr_ptr + 1'b1;
            cnt    <= cnt + 1'b1;
            if (cnt == plen - 1'b1) begin
              cnt   <= '0;
              state <= S_ARM;
            end
          end
          S_ARM: begin
            wr_ptr <= wr_ptr + 1'b1;
            if (real_fire || auto_fire) begin
              Triggered <= real_fire;
              rd_ptr    <= wr_ptr - plen;
              cnt       <= '0;
              if (plen == P_MAX) begin
                state   <= S_DONE;
                Cap_end <= 1'b1;
                empty   <= 1'b0;
              end else begin
                state <= S_POST;
              end
            end else begin
              if (arm_hit) armed <= 1'b1;
              if (tcnt != T_LAST) tcnt <= tcnt + 1'b1;
            end
          end
          S_POST: begin
            wr_ptr <= wr_ptr + 1'b1;
            cnt    <= cnt + 1'b1;
            if (cnt == post_last) begin
              state   <= S_DONE;
              Cap_end <= 1'b1;
              empty   <= 1'b0;
            end
          end
          S_DONE: begin
            if (rd_en && !empty) begin
              rd_data  <= ram[rd_ptr];
              rd_valid <= 1'b1;
              rd_ptr   <= rd_ptr + 1'b1;
              rd_cnt   <= rd_cnt + 1'b1;
              if (rd_cnt == P_MAX) empty <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
